// File: rtl/transaction_word_counter_if.sv
// Query/snoop bundle between the FIFO-out stage, the transaction FSM and the word counter.
// The slave modport belongs to the counter; the master modport drives pops, queries and init.
interface transaction_word_counter_if #(
    parameter int NUM_OUT     = 4,
    parameter int COUNT_WIDTH = 5,
    parameter int IDX_WIDTH   = $clog2(NUM_OUT)
) ();
    logic                   init;
    logic                   idle;
    logic [NUM_OUT-1:0]     pop;
    logic [NUM_OUT-1:0]     fifo_empty;
    logic                   req;
    logic [IDX_WIDTH-1:0]   idx;
    logic [COUNT_WIDTH-1:0] data;
    logic                   valid;

    modport master (
        output init, idle, pop, fifo_empty, req, idx,
        input  data, valid
    );

    modport slave (
        input  init, idle, pop, fifo_empty, req, idx,
        output data, valid
    );
endinterface

// File: rtl/transaction_word_counter.sv
// Purpose: counts non-empty pops per output FIFO and reports cnt[idx] on req while idle.
// Latency: count visible 1 cycle after the pop; data/valid registered 1 cycle after req.
// Backpressure: none; pops are snooped, req is a level query dropped while idle is low.
module transaction_word_counter #(
    parameter int NUM_OUT     = 4,
    parameter int COUNT_WIDTH = 5,
    parameter int IDX_WIDTH   = $clog2(NUM_OUT)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    transaction_word_counter_if.slave bus
);

    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q [NUM_OUT];
    logic [COUNT_WIDTH-1:0] cnt_d [NUM_OUT];
    logic [COUNT_WIDTH-1:0] data_q, data_d;
    logic [COUNT_WIDTH-1:0] sel_cnt;
    logic                   query;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_WAIT;
            data_q  <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            for (int i = 0; i < NUM_OUT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Counters wrap naturally at the register width; init beats a same-cycle pop.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.init) begin
                cnt_d[i] = '0;
            end else if (bus.pop[i] && !bus.fifo_empty[i]) begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
        end
    end

    // Select from the pre-increment counter so a colliding pop reports the old value.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (IDX_WIDTH'(i) == bus.idx) begin
                sel_cnt = cnt_q[i];
            end
        end
    end

    assign query = bus.req && bus.idle;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (bus.init) begin
            state_d = ST_WAIT;
            data_d  = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (query) begin
                        state_d = ST_REPORT;
                        data_d  = sel_cnt;
                    end
                end
                ST_REPORT: begin
                    if (query) begin
                        data_d = sel_cnt;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: state_d = ST_WAIT;
            endcase
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = (state_q == ST_REPORT);

endmodule

// File: tb/tb_transaction_word_counter.sv
// Randomised and directed checks of transaction_word_counter against a per-edge reference
// model that applies the counting and reporting rules with plain integer arithmetic.
module tb_transaction_word_counter;

    localparam int N  = 4;
    localparam int CW = 5;
    localparam int IW = 2;

    logic clk;
    logic reset_L;
    int   total;
    int   bad;

    int              m_cnt [N];
    logic [CW-1:0]   m_data;
    logic            m_valid;

    transaction_word_counter_if #(.NUM_OUT(N), .COUNT_WIDTH(CW), .IDX_WIDTH(IW)) bus ();

    transaction_word_counter #(.NUM_OUT(N), .COUNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_zero();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_data  = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge();
        int old [N];
        if (!reset_L) begin
            model_zero();
        end else begin
            for (int i = 0; i < N; i++) old[i] = m_cnt[i];
            if (bus.init) begin
                model_zero();
            end else begin
                for (int i = 0; i < N; i++)
                    if (bus.pop[i] && !bus.fifo_empty[i]) m_cnt[i] = (m_cnt[i] + 1) % 32;
                if (bus.req && bus.idle) begin
                    m_data  = CW'(old[int'(bus.idx)]);
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [N-1:0] pop, input logic [N-1:0] emp, input logic req,
                         input logic idle, input logic [IW-1:0] idx, input logic init);
        bus.pop        = pop;
        bus.fifo_empty = emp;
        bus.req        = req;
        bus.idle       = idle;
        bus.idx        = idx;
        bus.init       = init;
    endtask

    task automatic do_init();
        drive('0, '0, 1'b0, 1'b0, '0, 1'b1);
        cyc();
        drive('0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        drive('0, '0, 1'b0, 1'b0, '0, 1'b0);
        reset_L = 1'b1;
        #2 reset_L = 1'b0;
        model_zero();
        #1;
        total++;
        if (bus.data !== '0 || bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: data=%0d valid=%0b want data=0 valid=0", bus.data, bus.valid);
        end
        for (int k = 0; k < 6; k++) begin
            drive(N'($urandom), '0, 1'($urandom), 1'b1, IW'($urandom), 1'b0);
            cyc();
            total++;
            if (bus.data !== '0 || bus.valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: cyc=%0d data=%0d valid=%0b want 0/0", k, bus.data, bus.valid);
            end
        end
        drive('0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;
        for (int k = 0; k < N; k++) begin
            drive('0, '0, 1'b1, 1'b1, IW'(k), 1'b0);
            cyc();
            total++;
            if (bus.data !== '0 || bus.valid !== 1'b1) begin
                bad++;
                $display("FAIL reset_read: idx=%0d data=%0d valid=%0b want data=0 valid=1", k, bus.data, bus.valid);
            end
        end
    endtask

    task automatic test_basic_count();
        int npop [N] = '{2, 5, 2, 12};
        logic [N-1:0] p;
        do_init();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) p[i] = (k < npop[i]);
            drive(p, '0, 1'b0, 1'b1, '0, 1'b0);
            cyc();
        end
        for (int k = 0; k < N; k++) begin
            drive('0, '0, 1'b1, 1'b1, IW'(k), 1'b0);
            for (int c = 0; c < 2; c++) begin
                cyc();
                total++;
                if (bus.valid !== 1'b1 || bus.data !== CW'(npop[k]) || bus.data !== m_data) begin
                    bad++;
                    $display("FAIL basic_count: idx=%0d cyc=%0d data=%0d valid=%0b want data=%0d valid=1",
                             k, c, bus.data, bus.valid, npop[k]);
                end
            end
        end
    endtask

    task automatic test_empty_pops();
        do_init();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 4'b0100, 1'b0, 1'b1, '0, 1'b0);
            cyc();
        end
        drive(4'b0100, 4'b0000, 1'b0, 1'b1, '0, 1'b0);
        cyc();
        drive('0, '0, 1'b1, 1'b1, 2'd2, 1'b0);
        cyc();
        total++;
        if (bus.data !== 5'd1 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL empty_pops: data=%0d valid=%0b want data=1 valid=1", bus.data, bus.valid);
        end
    endtask

    task automatic test_wrap_simul();
        do_init();
        for (int k = 0; k < 33; k++) begin
            drive({1'b1, 2'b00, (k < 4)}, '0, 1'b0, 1'b1, '0, 1'b0);
            cyc();
        end
        drive('0, '0, 1'b1, 1'b1, 2'd3, 1'b0);
        cyc();
        total++;
        if (bus.data !== 5'd1) begin
            bad++;
            $display("FAIL wrap_cnt3: data=%0d want 1", bus.data);
        end
        drive('0, '0, 1'b1, 1'b1, 2'd0, 1'b0);
        cyc();
        total++;
        if (bus.data !== 5'd4) begin
            bad++;
            $display("FAIL simul_cnt0: data=%0d want 4", bus.data);
        end
    endtask

    task automatic test_gating_collision();
        do_init();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0010, '0, 1'b0, 1'b0, '0, 1'b0);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            drive('0, '0, 1'b1, 1'b0, 2'd1, 1'b0);
            cyc();
            total++;
            if (bus.valid !== 1'b0) begin
                bad++;
                $display("FAIL gate_idle: cyc=%0d valid=%0b want 0", k, bus.valid);
            end
        end
        drive(4'b0010, '0, 1'b1, 1'b1, 2'd1, 1'b0);
        cyc();
        total++;
        if (bus.valid !== 1'b1 || bus.data !== 5'd5) begin
            bad++;
            $display("FAIL collision_pre: data=%0d valid=%0b want data=5 valid=1", bus.data, bus.valid);
        end
        drive('0, '0, 1'b1, 1'b1, 2'd1, 1'b0);
        cyc();
        total++;
        if (bus.valid !== 1'b1 || bus.data !== 5'd6) begin
            bad++;
            $display("FAIL collision_post: data=%0d valid=%0b want data=6 valid=1", bus.data, bus.valid);
        end
        drive('0, '0, 1'b0, 1'b1, 2'd1, 1'b0);
        cyc();
        total++;
        if (bus.valid !== 1'b0 || bus.data !== 5'd6) begin
            bad++;
            $display("FAIL valid_fall: data=%0d valid=%0b want data=6 valid=0", bus.data, bus.valid);
        end
    endtask

    task automatic test_init_reset();
        drive('0, '0, 1'b1, 1'b1, 2'd1, 1'b0);
        cyc();
        drive(4'b1111, '0, 1'b1, 1'b1, 2'd1, 1'b1);
        cyc();
        total++;
        if (bus.valid !== 1'b0 || bus.data !== '0) begin
            bad++;
            $display("FAIL init_edge: data=%0d valid=%0b want 0/0", bus.data, bus.valid);
        end
        for (int k = 0; k < N; k++) begin
            drive('0, '0, 1'b1, 1'b1, IW'(k), 1'b0);
            cyc();
            total++;
            if (bus.data !== '0 || bus.valid !== 1'b1) begin
                bad++;
                $display("FAIL init_read: idx=%0d data=%0d valid=%0b want data=0 valid=1", k, bus.data, bus.valid);
            end
        end
        drive(4'b0001, '0, 1'b1, 1'b1, 2'd0, 1'b0);
        cyc();
        cyc();
        #2 reset_L = 1'b0;
        model_zero();
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.data !== '0) begin
            bad++;
            $display("FAIL reset_mid_report: data=%0d valid=%0b want 0/0", bus.data, bus.valid);
        end
        drive('0, '0, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;
        drive('0, '0, 1'b1, 1'b1, 2'd0, 1'b0);
        cyc();
        total++;
        if (bus.data !== '0 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_clears_cnt: data=%0d valid=%0b want data=0 valid=1", bus.data, bus.valid);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(N'($urandom), N'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                  IW'($urandom), ($urandom_range(24) == 0));
            cyc();
            total++;
            if (bus.valid !== m_valid || bus.data !== m_data) begin
                bad++;
                $display("FAIL random: step=%0d data=%0d valid=%0b want data=%0d valid=%0b",
                         k, bus.data, bus.valid, m_data, m_valid);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_zero();
        test_reset();
        test_basic_count();
        test_empty_pops();
        test_wrap_simul();
        test_gating_collision();
        test_init_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transaction_word_counter.md
# transaction_word_counter

Counts words popped from each of the four output FIFOs of the transaction layer and reports a selected count on request. It sits directly downstream of the FIFO-out stage and snoops each FIFO's pop strobe and empty flag. It answers a `req`/`idx` query with a registered `data`/`valid` pair, but only while the control FSM reports IDLE. `init` clears all counts.

## Interface
- `NUM_OUT`, default 4: number of output FIFOs monitored.
- `COUNT_WIDTH`, default 5: width of each counter and of `data`.
- `IDX_WIDTH`, default `$clog2(NUM_OUT)` = 2: width of `idx`.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_L` input 1: reset, asynchronous, active-low.
- `init` input 1: synchronous clear of all counters and return to WAIT.
- `idle` input 1: high when the transaction FSM is in IDLE; reporting is enabled only while high.
- `pop` input `NUM_OUT`: pop strobes to FIFO out 0..3.
- `fifo_empty` input `NUM_OUT`: empty flags of FIFO out 0..3, as seen in the same cycle as `pop`.
- `req` input 1: count request.
- `idx` input `IDX_WIDTH`: counter select for `req`.
- `data` output `COUNT_WIDTH`: reported count.
- `valid` output 1: `data` is valid.

## Operation
- **Counters:**
  - Four `COUNT_WIDTH`-bit counters `cnt[i]`.
  - `cnt[i]` increments by 1 on a clock edge where `pop[i]=1` and `fifo_empty[i]=0`.
  - A pop on an empty FIFO is not counted.
  - Counting is independent of `idle`, `req` and the FSM state.
- **Wrap-around:** counters wrap modulo 2^`COUNT_WIDTH` (31 -> 0). There is no saturation and no overflow flag.
- **Simultaneous pops:** pops on several FIFOs in one cycle increment each corresponding counter independently.
- **Reporting FSM:**
  - WAIT: `valid=0`, `data` holds its last value.
    - Goes to REPORT when `req=1` and `idle=1` and `init=0`.
  - REPORT: `valid=1`, `data` is reloaded every cycle with `cnt[idx]`.
    - Stays in REPORT while `req=1` and `idle=1`.
    - Goes to WAIT when `req=0` or `idle=0`.
- **Index change:** an `idx` change while in REPORT takes effect on the next edge. There is no return through WAIT.
- **Non-destructive read:** reads do not clear counters.
- **init:**
  - Clears all counters to 0, clears `data` to 0 and forces WAIT (`valid=0`).
  - Has priority over a same-cycle pop and a same-cycle req.
- **`req` while `idle=0`:** ignored. `valid` stays 0 and there is no queued request.

## Timing
- **Reset:** asynchronous assertion of `reset_L=0` immediately forces all counters to 0, `data=0`, `valid=0` and state WAIT. Release is synchronous to the next edge; counting resumes on the first edge with `reset_L=1`.
- **Reset mid-operation:** a reset during REPORT drops `valid` without waiting for a clock edge.
- **Count latency:** 1 cycle. A pop sampled at edge N is visible in `cnt` after edge N.
- **Report latency:** 1 cycle. With `req`, `idle` and `idx` sampled high/valid at edge N, `data=cnt[idx]` (value before edge N's increment) and `valid=1` after edge N.
- **Pop/read collision:** a pop and a read of the same counter at the same edge report the pre-increment value; the incremented value appears one cycle later if `req` is still held.
- **valid deassertion:** `valid` falls one cycle after `req` or `idle` falls.
- **init:** takes effect at the edge where it is sampled high. Counting restarts on the following edge.

## Test plan
- **Reset:**
  - Stimulus: hold `reset_L=0` with random `pop`/`req`.
  - Required: `data=0` and `valid=0` throughout.
  - Stimulus: after release, read `idx` 0..3.
  - Required: `data=0` for each.
- **Basic count:**
  - Stimulus: with `fifo_empty=0`, pop FIFO0 2x, FIFO1 5x, FIFO2 2x, FIFO3 12x; then `idle=1`, `req=1`, stepping `idx` 0,1,2,3 with 2 cycles each.
  - Required: `data`=2, 5, 2, 12 in turn, each valid 1 cycle after the `idx` change.
- **Empty pops:**
  - Stimulus: 3 pops on FIFO2 with `fifo_empty[2]=1`, then 1 pop with `fifo_empty[2]=0`.
  - Required: read of `idx`=2 returns 1.
- **Wrap-around and simultaneous pops:**
  - Stimulus: pop FIFO3 33 times, concurrently popping FIFO0 4 times in the same cycles.
  - Required: `cnt[3]` reads 1 and `cnt[0]` reads 4.
- **Gating and collision:**
  - Stimulus: `req=1` with `idle=0`.
    - Required: `valid` stays 0.
  - Stimulus: raise `idle`.
    - Required: `valid=1` on the next edge.
  - Stimulus: pop FIFO1 in the same cycle as the read of `idx`=1 (count 5).
    - Required: `data=5`, then `data=6` on the next cycle.
- **init and async reset mid-REPORT:**
  - Stimulus: `init=1` with counts nonzero and a concurrent pop.
    - Required: all reads return 0 and `valid` drops on that edge.
  - Stimulus: assert `reset_L=0` between edges while `valid=1`.
    - Required: `valid=0` immediately.
